// File: rtl/serial_ripple_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master side drives operands and takes results; the slave side is the subtractor.
interface serial_ripple_subtractor_if #(
    parameter int SIZE = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            bi;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] diff;
    logic            bo;

    modport master (
        output in_valid, a, b, bi, out_ready,
        input  in_ready, out_valid, diff, bo
    );

    modport slave (
        input  in_valid, a, b, bi, out_ready,
        output in_ready, out_valid, diff, bo
    );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple subtractor, diff = a - b - bi, one bit per cycle LSB first.
// Latency: SIZE edges from accept to out_valid; one operation per SIZE+2 cycles.
// Backpressure: result held in DONE until out_ready; no new operands accepted until then.
module serial_ripple_subtractor #(
    parameter int SIZE = 4
) (
    input logic                       clk,
    input logic                       rst_n,
    serial_ripple_subtractor_if.slave bus
);
    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] a_sh;
    logic [SIZE-1:0] b_sh;
    logic [SIZE-1:0] diff_q;
    logic            br;
    logic            bo_q;

    logic a_k;
    logic b_k;
    logic d_k;
    logic br_nxt;

    // One full-subtractor cell, fed from the low end of the operand shifters.
    always_comb begin
        a_k    = a_sh[0];
        b_k    = b_sh[0];
        d_k    = a_k ^ b_k ^ br;
        br_nxt = (~a_k & b_k) | (~(a_k ^ b_k) & br);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            br     <= 1'b0;
            bo_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        br    <= bus.bi;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_nxt;
                    // New bit enters at the MSB so after SIZE shifts bit 0 sits at the LSB.
                    diff_q <= (diff_q >> 1) | (SIZE'(d_k) << (SIZE - 1));
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bo_q  <= br_nxt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.bo        = bo_q;
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor at SIZE=4 and SIZE=1 against an arithmetic model.
module tb_serial_ripple_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_ripple_subtractor_if #(.SIZE(4)) s4 ();
    serial_ripple_subtractor_if #(.SIZE(1)) s1 ();

    serial_ripple_subtractor #(.SIZE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(s4));
    serial_ripple_subtractor #(.SIZE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(s1));

    function automatic logic [3:0] ref_diff4(input int a, input int b, input int c);
        return 4'((a - b - c + 32) % 16);
    endfunction

    function automatic logic ref_bo(input int a, input int b, input int c);
        return (a < b + c);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (s4.in_ready !== 1'b1 || s4.out_valid !== 1'b0 || s4.diff !== 4'h0 || s4.bo !== 1'b0) begin
            fails++;
            $display("FAIL reset4: in_ready=%b out_valid=%b diff=%h bo=%b, want 1 0 0 0",
                     s4.in_ready, s4.out_valid, s4.diff, s4.bo);
        end
        tests++;
        if (s1.in_ready !== 1'b1 || s1.out_valid !== 1'b0 || s1.diff !== 1'b0 || s1.bo !== 1'b0) begin
            fails++;
            $display("FAIL reset1: in_ready=%b out_valid=%b diff=%b bo=%b, want 1 0 0 0",
                     s1.in_ready, s1.out_valid, s1.diff, s1.bo);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (s4.in_ready !== 1'b1 || s4.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, want 1 0", s4.in_ready, s4.out_valid);
        end
    endtask

    // Directed vectors with out_ready already high: checks latency and single-cycle out_valid.
    task automatic test_directed();
        int va[4] = '{9, 3, 0, 15};
        int vb[4] = '{3, 9, 0, 15};
        int vc[4] = '{0, 0, 1, 1};
        int lat;
        logic [3:0] ed;
        logic eb;
        for (int i = 0; i < 4; i++) begin
            ed = ref_diff4(va[i], vb[i], vc[i]);
            eb = ref_bo(va[i], vb[i], vc[i]);
            s4.a = 4'(va[i]);
            s4.b = 4'(vb[i]);
            s4.bi = vc[i][0];
            s4.in_valid = 1'b1;
            s4.out_ready = 1'b1;
            @(negedge clk);
            s4.in_valid = 1'b0;
            lat = 0;
            while (s4.out_valid !== 1'b1 && lat < 20) begin
                tests++;
                if (s4.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL run_in_ready vec%0d: in_ready=%b, want 0", i, s4.in_ready);
                end
                @(negedge clk);
                lat++;
            end
            tests++;
            if (lat != 4) begin
                fails++;
                $display("FAIL latency vec%0d: got %0d edges, want 4", i, lat);
            end
            tests++;
            if (s4.diff !== ed || s4.bo !== eb) begin
                fails++;
                $display("FAIL directed vec%0d: diff=%h bo=%b, want diff=%h bo=%b", i, s4.diff, s4.bo, ed, eb);
            end
            @(negedge clk);
            tests++;
            if (s4.out_valid !== 1'b0 || s4.in_ready !== 1'b1 || s4.diff !== ed || s4.bo !== eb) begin
                fails++;
                $display("FAIL one_cycle_valid vec%0d: out_valid=%b in_ready=%b diff=%h bo=%b, want 0 1 %h %b",
                         i, s4.out_valid, s4.in_ready, s4.diff, s4.bo, ed, eb);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3:0] ed;
        logic eb;
        ed = ref_diff4(12, 5, 1);
        eb = ref_bo(12, 5, 1);
        s4.a = 4'd12;
        s4.b = 4'd5;
        s4.bi = 1'b1;
        s4.in_valid = 1'b1;
        s4.out_ready = 1'b0;
        @(negedge clk);
        s4.in_valid = 1'b0;
        lat = 0;
        while (s4.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (s4.out_valid !== 1'b1 || s4.diff !== ed || s4.bo !== eb) begin
            fails++;
            $display("FAIL bp_result: out_valid=%b diff=%h bo=%b, want 1 %h %b", s4.out_valid, s4.diff, s4.bo, ed, eb);
        end
        for (int i = 0; i < 5; i++) begin
            s4.in_valid = ~s4.in_valid;
            s4.a = 4'($urandom);
            s4.b = 4'($urandom);
            s4.bi = 1'($urandom);
            @(negedge clk);
            tests++;
            if (s4.out_valid !== 1'b1 || s4.in_ready !== 1'b0 || s4.diff !== ed || s4.bo !== eb) begin
                fails++;
                $display("FAIL bp_hold cyc%0d: out_valid=%b in_ready=%b diff=%h bo=%b, want 1 0 %h %b",
                         i, s4.out_valid, s4.in_ready, s4.diff, s4.bo, ed, eb);
            end
        end
        s4.in_valid = 1'b0;
        s4.out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (s4.in_ready !== 1'b1 || s4.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", s4.in_ready, s4.out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        s4.a = 4'd9;
        s4.b = 4'd3;
        s4.bi = 1'b0;
        s4.in_valid = 1'b1;
        s4.out_ready = 1'b1;
        @(negedge clk);
        s4.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (s4.in_ready !== 1'b1 || s4.out_valid !== 1'b0 || s4.diff !== 4'h0 || s4.bo !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run: in_ready=%b out_valid=%b diff=%h bo=%b, want 1 0 0 0",
                     s4.in_ready, s4.out_valid, s4.diff, s4.bo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s4.a = 4'd5;
        s4.b = 4'd2;
        s4.bi = 1'b0;
        s4.in_valid = 1'b1;
        @(negedge clk);
        s4.in_valid = 1'b0;
        lat = 0;
        while (s4.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (s4.out_valid !== 1'b1 || s4.diff !== 4'd3 || s4.bo !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_op: out_valid=%b diff=%h bo=%b, want 1 3 0", s4.out_valid, s4.diff, s4.bo);
        end
        @(negedge clk);
    endtask

    // in_valid held high throughout: each result must follow the previous by SIZE+2 cycles.
    task automatic test_back_to_back();
        int va[4] = '{7, 2, 15, 8};
        int vb[4] = '{1, 6, 0, 8};
        int vc[4] = '{1, 0, 1, 0};
        int gap;
        s4.out_ready = 1'b1;
        s4.in_valid = 1'b1;
        s4.a = 4'(va[0]);
        s4.b = 4'(vb[0]);
        s4.bi = vc[0][0];
        for (int i = 0; i < 4; i++) begin
            gap = 0;
            @(negedge clk);
            gap++;
            while (s4.out_valid !== 1'b1 && gap < 30) begin
                @(negedge clk);
                gap++;
            end
            tests++;
            if (s4.diff !== ref_diff4(va[i], vb[i], vc[i]) || s4.bo !== ref_bo(va[i], vb[i], vc[i])) begin
                fails++;
                $display("FAIL b2b_result op%0d: diff=%h bo=%b, want diff=%h bo=%b", i, s4.diff, s4.bo,
                         ref_diff4(va[i], vb[i], vc[i]), ref_bo(va[i], vb[i], vc[i]));
            end
            if (i > 0) begin
                tests++;
                if (gap != 6) begin
                    fails++;
                    $display("FAIL b2b_gap op%0d: got %0d cycles, want 6", i, gap);
                end
            end
            if (i < 3) begin
                s4.a = 4'(va[i+1]);
                s4.b = 4'(vb[i+1]);
                s4.bi = vc[i+1][0];
            end
        end
        s4.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random4();
        int lat;
        int n;
        logic [3:0] ed;
        logic eb;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    ed = ref_diff4(a, b, c);
                    eb = ref_bo(a, b, c);
                    s4.a = 4'(a);
                    s4.b = 4'(b);
                    s4.bi = c[0];
                    s4.in_valid = 1'b1;
                    s4.out_ready = 1'b0;
                    @(negedge clk);
                    s4.in_valid = 1'b0;
                    s4.a = 4'($urandom);
                    s4.b = 4'($urandom);
                    s4.bi = 1'($urandom);
                    lat = 0;
                    while (s4.out_valid !== 1'b1 && lat < 20) begin
                        @(negedge clk);
                        lat++;
                    end
                    tests++;
                    if (s4.out_valid !== 1'b1 || s4.diff !== ed || s4.bo !== eb) begin
                        fails++;
                        $display("FAIL rand4 a=%0d b=%0d bi=%0d: valid=%b diff=%h bo=%b, want 1 %h %b",
                                 a, b, c, s4.out_valid, s4.diff, s4.bo, ed, eb);
                    end
                    n = 0;
                    while (n < 50) begin
                        s4.out_ready = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                        @(negedge clk);
                        n++;
                        if (s4.out_ready) break;
                        tests++;
                        if (s4.out_valid !== 1'b1 || s4.diff !== ed || s4.bo !== eb) begin
                            fails++;
                            $display("FAIL rand4_stall a=%0d b=%0d bi=%0d: valid=%b diff=%h bo=%b",
                                     a, b, c, s4.out_valid, s4.diff, s4.bo);
                        end
                    end
                    tests++;
                    if (s4.out_valid !== 1'b0 || s4.in_ready !== 1'b1) begin
                        fails++;
                        $display("FAIL rand4_release: out_valid=%b in_ready=%b, want 0 1", s4.out_valid, s4.in_ready);
                    end
                end
            end
        end
        s4.out_ready = 1'b0;
    endtask

    task automatic test_random1();
        int lat;
        int n;
        logic ed;
        logic eb;
        for (int k = 0; k < 40; k++) begin
            int a = (k < 8) ? k[2] : int'($urandom_range(0, 1));
            int b = (k < 8) ? k[1] : int'($urandom_range(0, 1));
            int c = (k < 8) ? k[0] : int'($urandom_range(0, 1));
            ed = 1'((a - b - c + 4) % 2);
            eb = ref_bo(a, b, c);
            s1.a = a[0];
            s1.b = b[0];
            s1.bi = c[0];
            s1.in_valid = 1'b1;
            s1.out_ready = 1'b0;
            @(negedge clk);
            s1.in_valid = 1'b0;
            lat = 0;
            while (s1.out_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            tests++;
            if (s1.out_valid !== 1'b1 || lat != 1 || s1.diff !== ed || s1.bo !== eb) begin
                fails++;
                $display("FAIL rand1 a=%0d b=%0d bi=%0d: valid=%b lat=%0d diff=%b bo=%b, want 1 1 %b %b",
                         a, b, c, s1.out_valid, lat, s1.diff, s1.bo, ed, eb);
            end
            n = 0;
            while (n < 50) begin
                s1.out_ready = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
                if (s1.out_ready) break;
                tests++;
                if (s1.out_valid !== 1'b1 || s1.diff !== ed || s1.bo !== eb) begin
                    fails++;
                    $display("FAIL rand1_stall a=%0d b=%0d bi=%0d: valid=%b diff=%b bo=%b",
                             a, b, c, s1.out_valid, s1.diff, s1.bo);
                end
            end
            tests++;
            if (s1.out_valid !== 1'b0 || s1.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL rand1_release: out_valid=%b in_ready=%b, want 0 1", s1.out_valid, s1.in_ready);
            end
        end
        s1.out_ready = 1'b0;
    endtask

    initial begin
        s4.in_valid = 1'b0;
        s4.a = '0;
        s4.b = '0;
        s4.bi = 1'b0;
        s4.out_ready = 1'b0;
        s1.in_valid = 1'b0;
        s1.a = '0;
        s1.b = '0;
        s1.bi = 1'b0;
        s1.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random4();
        test_random1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
